// File: rtl/noise_pkg.sv
// Shared constants, lookup tables and register layouts for the APU noise voice.
package noise_pkg;

  localparam int unsigned REG_W         = 8;
  localparam int unsigned LEN_W         = 8;
  localparam int unsigned TAP_LONG      = 1;
  localparam int unsigned TAP_SHORT_DEF = 6;
  localparam int unsigned LFSR_W_DEF    = 15;

  localparam logic [7:0] LENGTH_TABLE [32] = '{
    8'h0A, 8'hFE, 8'h14, 8'h02, 8'h28, 8'h04, 8'h50, 8'h06,
    8'hA0, 8'h08, 8'h3C, 8'h0A, 8'h0E, 8'h0C, 8'h1A, 8'h0E,
    8'h0C, 8'h10, 8'h18, 8'h12, 8'h30, 8'h14, 8'h60, 8'h16,
    8'hC0, 8'h18, 8'h48, 8'h1A, 8'h10, 8'h1C, 8'h20, 8'h1E
  };

  localparam logic [11:0] PERIOD_TABLE [16] = '{
    12'h004, 12'h008, 12'h010, 12'h020, 12'h040, 12'h060, 12'h080, 12'h0A0,
    12'h0CA, 12'h0FE, 12'h17C, 12'h1FC, 12'h2FA, 12'h3F8, 12'h7F2, 12'hFE4
  };

  typedef struct packed {
    logic [1:0] rsvd;
    logic       halt_loop;
    logic       const_vol;
    logic [3:0] vol_period;
  } reg_400c_t;

  typedef struct packed {
    logic       mode;
    logic [2:0] rsvd;
    logic [3:0] period_sel;
  } reg_400e_t;

endpackage

// File: rtl/noise_if.sv
// Register/strobe bus between the register-file crossing, the noise voice and the mixer.
interface noise_if
  import noise_pkg::*;
#(
  parameter int unsigned VOL_WIDTH = 4
);
  logic                 enable_240hz;
  logic                 enable_120hz;
  logic                 channel_enable;
  logic [REG_W-1:0]     reg_400C;
  logic [REG_W-1:0]     reg_400E;
  logic [REG_W-1:0]     reg_400F;
  logic                 reg_change;
  logic                 length_active;
  logic [VOL_WIDTH-1:0] noise_out;

  modport master (
    output enable_240hz, enable_120hz, channel_enable,
    output reg_400C, reg_400E, reg_400F, reg_change,
    input  length_active, noise_out
  );

  modport slave (
    input  enable_240hz, enable_120hz, channel_enable,
    input  reg_400C, reg_400E, reg_400F, reg_change,
    output length_active, noise_out
  );
endinterface

// File: rtl/noise_envelope_unit.sv
// Decaying/looping volume envelope clocked by the quarter-frame strobe.
module envelope_unit
  import noise_pkg::*;
#(
  parameter int unsigned VOL_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_set,
  input  logic                 quarter,
  input  logic [VOL_WIDTH-1:0] period,
  input  logic                 loop,
  input  logic                 const_vol,
  output logic [VOL_WIDTH-1:0] volume_c
);

  logic                 start_q, start_d;
  logic [VOL_WIDTH-1:0] div_q, div_d;
  logic [VOL_WIDTH-1:0] decay_q, decay_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      div_q   <= '0;
      decay_q <= '0;
    end else begin
      start_q <= start_d;
      div_q   <= div_d;
      decay_q <= decay_d;
    end
  end

  // A write arriving with a strobe only arms start; the next strobe consumes it.
  always_comb begin
    start_d = start_q;
    div_d   = div_q;
    decay_d = decay_q;
    if (start_set) begin
      start_d = 1'b1;
    end else if (quarter) begin
      if (start_q) begin
        start_d = 1'b0;
        decay_d = '1;
        div_d   = period;
      end else if (div_q == '0) begin
        div_d = period;
        if (decay_q != '0) begin
          decay_d = decay_q - VOL_WIDTH'(1);
        end else if (loop) begin
          decay_d = '1;
        end
      end else begin
        div_d = div_q - VOL_WIDTH'(1);
      end
    end
  end

  assign volume_c = const_vol ? period : decay_q;

endmodule

// File: rtl/noise_channel.sv
// APU noise voice: prescaled timer stepping an LFSR, length counter, envelope, registered sample.
module noise_channel
  import noise_pkg::*;
#(
  parameter int unsigned LFSR_WIDTH  = LFSR_W_DEF,
  parameter int unsigned TAP_SHORT   = TAP_SHORT_DEF,
  parameter int unsigned TIMER_WIDTH = 12,
  parameter int unsigned VOL_WIDTH   = 4,
  parameter int unsigned CLK_DIV     = 1
) (
  input  logic    clk,
  input  logic    rst,
  noise_if.slave  bus
);

  reg_400c_t cfg_c;
  reg_400e_t cfg_e;
  logic      unused_bits;

  assign cfg_c       = reg_400c_t'(bus.reg_400C);
  assign cfg_e       = reg_400e_t'(bus.reg_400E);
  assign unused_bits = ^{cfg_c.rsvd, cfg_e.rsvd, bus.reg_400F[2:0]};

  // Write detect: reg_change toggles in a foreign domain, so synchronise then edge-detect.
  logic [1:0] sync_q;
  logic       reload_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      reload_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], bus.reg_change};
      reload_q <= sync_q[0] ^ sync_q[1];
    end
  end

  logic tick;

  if (CLK_DIV <= 1) begin : g_nodiv
    assign tick = 1'b1;
  end else begin : g_div
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        div_q <= '0;
      end else if (div_q == '0) begin
        div_q <= DIV_W'(CLK_DIV - 1);
      end else begin
        div_q <= div_q - DIV_W'(1);
      end
    end

    assign tick = (div_q == '0);
  end

  // New periods are only picked up at reload, so a running count is never cut short.
  logic [TIMER_WIDTH-1:0] timer_q;
  logic                   step;

  assign step = tick && (timer_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (tick) begin
      if (timer_q == '0) begin
        timer_q <= TIMER_WIDTH'(PERIOD_TABLE[cfg_e.period_sel]);
      end else begin
        timer_q <= timer_q - TIMER_WIDTH'(1);
      end
    end
  end

  logic [LFSR_WIDTH-1:0] lfsr_q;
  logic                  fb;

  assign fb = lfsr_q[0] ^ (cfg_e.mode ? lfsr_q[TAP_SHORT] : lfsr_q[TAP_LONG]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_WIDTH'(1);
    end else if (step) begin
      lfsr_q <= {fb, lfsr_q[LFSR_WIDTH-1:1]};
    end else if (lfsr_q == '0) begin
      lfsr_q <= LFSR_WIDTH'(1);
    end
  end

  // Disable beats reload, reload beats the half-frame decrement.
  logic [LEN_W-1:0] length_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      length_q <= '0;
    end else if (!bus.channel_enable) begin
      length_q <= '0;
    end else if (reload_q) begin
      length_q <= LEN_W'(LENGTH_TABLE[bus.reg_400F[7:3]]);
    end else if (bus.enable_120hz && !cfg_c.halt_loop && (length_q != '0)) begin
      length_q <= length_q - LEN_W'(1);
    end
  end

  logic [VOL_WIDTH-1:0] volume_c;

  envelope_unit #(
    .VOL_WIDTH (VOL_WIDTH)
  ) u_env (
    .clk       (clk),
    .rst       (rst),
    .start_set (reload_q),
    .quarter   (bus.enable_240hz),
    .period    (VOL_WIDTH'(cfg_c.vol_period)),
    .loop      (cfg_c.halt_loop),
    .const_vol (cfg_c.const_vol),
    .volume_c  (volume_c)
  );

  logic [VOL_WIDTH-1:0] noise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noise_q <= '0;
    end else if ((length_q == '0) || lfsr_q[0]) begin
      noise_q <= '0;
    end else begin
      noise_q <= volume_c;
    end
  end

  assign bus.noise_out     = noise_q;
  assign bus.length_active = (length_q != '0);

endmodule

// File: tb/tb_noise_channel.sv
// Directed bench for noise_channel: reset, LFSR sequencing, prescaler, length, envelope, output gating.
module tb_noise_channel;

  logic clk = 1'b0;
  logic rst = 1'b0;

  noise_if #(.VOL_WIDTH(4)) intf  ();
  noise_if #(.VOL_WIDTH(4)) intf4 ();

  noise_channel #(.CLK_DIV(1)) dut  (.clk(clk), .rst(rst), .bus(intf.slave));
  noise_channel #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(intf4.slave));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    intf.reg_change = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  // Toggle reg_change; optional strobes land on the same edge that applies the reload.
  task automatic write_400f(input logic [7:0] v, input logic with_120, input logic with_240);
    intf.reg_400F   = v;
    intf.reg_change = ~intf.reg_change;
    cyc(2);
    intf.enable_120hz = with_120;
    intf.enable_240hz = with_240;
    cyc(1);
    intf.enable_120hz = 1'b0;
    intf.enable_240hz = 1'b0;
  endtask

  task automatic strobe120(input int n);
    repeat (n) begin
      intf.enable_120hz = 1'b1;
      cyc(1);
      intf.enable_120hz = 1'b0;
      cyc(1);
    end
  endtask

  task automatic strobe240();
    intf.enable_240hz = 1'b1;
    cyc(1);
    intf.enable_240hz = 1'b0;
    cyc(1);
  endtask

  // Reference LFSR for dut (period select held at 0 -> step every 5 clk)
  logic [14:0] m_lfsr;
  logic [11:0] m_timer;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr  <= 15'd1;
      m_timer <= 12'd0;
    end else if (m_timer == 12'd0) begin
      m_timer <= 12'd4;
      m_lfsr  <= {m_lfsr[0] ^ (intf.reg_400E[7] ? m_lfsr[6] : m_lfsr[1]), m_lfsr[14:1]};
    end else begin
      m_timer <= m_timer - 12'd1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first;
    int pulses;
    logic prev_bit;
    logic [3:0] exp_v;
    int seen7;
    int seen0;

    intf.enable_240hz = 0; intf.enable_120hz = 0; intf.channel_enable = 0;
    intf.reg_400C = 0; intf.reg_400E = 0; intf.reg_400F = 0; intf.reg_change = 0;
    intf4.enable_240hz = 0; intf4.enable_120hz = 0; intf4.channel_enable = 0;
    intf4.reg_400C = 0; intf4.reg_400E = 0; intf4.reg_400F = 0; intf4.reg_change = 0;

    #2 rst = 1'b1;
    #1;
    check("rst_noise_out", 32'(intf.noise_out), 32'd0);
    check("rst_length_active", 32'(intf.length_active), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr_q), 32'd1);

    // LFSR long mode first states, and prescaled copy
    @(negedge clk);
    do_reset();
    cyc(1);
    check("lfsr_step1", 32'(dut.lfsr_q), 32'h4000);
    check("div4_step1", 32'(dut4.lfsr_q), 32'h4000);
    cyc(4);
    check("lfsr_hold", 32'(dut.lfsr_q), 32'h4000);
    cyc(1);
    check("lfsr_step2", 32'(dut.lfsr_q), 32'h2000);
    cyc(14);
    check("div4_hold", 32'(dut4.lfsr_q), 32'h4000);
    cyc(1);
    check("div4_step2", 32'(dut4.lfsr_q), 32'h2000);

    // Short mode: seed 1 returns after 93 steps
    intf.reg_400E = 8'h80;
    do_reset();
    first = -1;
    cyc(1);
    for (int s = 1; s <= 93; s++) begin
      if (s > 1) cyc(5);
      check("lfsr_model", 32'(dut.lfsr_q), 32'(m_lfsr));
      if (first < 0 && dut.lfsr_q == 15'd1) first = s;
    end
    check("short_period", 32'(first), 32'd93);
    intf.reg_400E = 8'h00;

    // Length counter
    intf.channel_enable = 1'b1;
    intf.reg_400C = 8'h00;
    intf.reg_400F = 8'h08;
    intf.reg_change = ~intf.reg_change;
    cyc(2);
    check("len_not_yet", 32'(intf.length_active), 32'd0);
    cyc(1);
    check("len_load", 32'(dut.length_q), 32'hFE);
    check("len_active", 32'(intf.length_active), 32'd1);
    strobe120(253);
    check("len_253", 32'(dut.length_q), 32'd1);
    check("len_active_253", 32'(intf.length_active), 32'd1);
    strobe120(1);
    check("len_expire", 32'(intf.length_active), 32'd0);
    cyc(1);
    check("len_zero_out", 32'(intf.noise_out), 32'd0);

    write_400f(8'h08, 1'b0, 1'b0);
    strobe120(1);
    check("len_dec", 32'(dut.length_q), 32'hFD);
    write_400f(8'h08, 1'b1, 1'b0);
    check("reload_beats_120", 32'(dut.length_q), 32'hFE);
    intf.reg_400C = 8'h20;
    strobe120(10);
    check("len_halt", 32'(dut.length_q), 32'hFE);
    intf.reg_400C = 8'h00;
    strobe120(1);
    check("len_unhalt", 32'(dut.length_q), 32'hFD);
    write_400f(8'h00, 1'b0, 1'b0);
    check("len_sel0", 32'(dut.length_q), 32'h0A);
    intf.channel_enable = 1'b0;
    cyc(1);
    check("len_disable", 32'(dut.length_q), 32'd0);
    check("len_disable_active", 32'(intf.length_active), 32'd0);
    write_400f(8'h08, 1'b0, 1'b0);
    check("reload_disabled", 32'(dut.length_q), 32'd0);
    intf.channel_enable = 1'b1;

    // Envelope decay, hold, loop, divider, coincident start
    intf.reg_400C = 8'h00;
    write_400f(8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      strobe240();
      check("env_decay", 32'(dut.u_env.decay_q), 32'(16 - k));
    end
    strobe240();
    check("env_hold0", 32'(dut.u_env.decay_q), 32'd0);
    intf.reg_400C = 8'h20;
    strobe240();
    check("env_loop", 32'(dut.u_env.decay_q), 32'hF);
    intf.reg_400C = 8'h02;
    write_400f(8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      strobe240();
      check("env_div_wait", 32'(dut.u_env.decay_q), 32'hF);
    end
    strobe240();
    check("env_div_step", 32'(dut.u_env.decay_q), 32'hE);
    intf.reg_400C = 8'h00;
    write_400f(8'h00, 1'b0, 1'b1);
    check("env_coincide_hold", 32'(dut.u_env.decay_q), 32'hE);
    strobe240();
    check("env_coincide_next", 32'(dut.u_env.decay_q), 32'hF);

    // Constant volume gated by LFSR bit 0, one clk latency
    intf.reg_400C = 8'h17;
    check("const_len_active", 32'(intf.length_active), 32'd1);
    cyc(1);
    prev_bit = m_lfsr[0];
    seen7 = 0;
    seen0 = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      exp_v = prev_bit ? 4'd0 : 4'd7;
      check("const_vol", 32'(intf.noise_out), 32'(exp_v));
      if (exp_v == 4'd7) seen7 = 1; else seen0 = 1;
      prev_bit = m_lfsr[0];
    end
    check("const_saw7", 32'(seen7), 32'd1);
    check("const_saw0", 32'(seen0), 32'd1);

    // Asynchronous reset mid-run, then exactly one reload from one toggle
    #2 rst = 1'b1;
    intf.reg_change = 1'b0;
    #1;
    check("midrst_noise_out", 32'(intf.noise_out), 32'd0);
    check("midrst_length_active", 32'(intf.length_active), 32'd0);
    check("midrst_lfsr", 32'(dut.lfsr_q), 32'd1);
    check("midrst_decay", 32'(dut.u_env.decay_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    intf.reg_400F = 8'h08;
    intf.reg_change = 1'b1;
    pulses = 0;
    repeat (8) begin
      cyc(1);
      if (dut.reload_q) pulses++;
    end
    check("reload_once", 32'(pulses), 32'd1);
    check("post_rst_len", 32'(dut.length_q), 32'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noise_channel.md
Name: noise_channel

Overview:
Parametrised second-generation APU noise voice: timer-clocked LFSR, length counter, and a full decaying envelope unit. It adds a clock prescaler, channel enable, loop/decay envelope, and separate quarter- and half-frame strobes. Sits between the register-file clock-crossing block and the mixer. One instance serves $400C/$400E/$400F.

Parameters:
LFSR_WIDTH, 15, shift-register length; feedback is written into bit LFSR_WIDTH-1.
TAP_SHORT, 6, second feedback tap when mode=1; the tap is bit 1 when mode=0.
TIMER_WIDTH, 12, timer and period-table width.
VOL_WIDTH, 4, envelope, decay and output width.
CLK_DIV, 1, number of clk cycles per timer tick (1 = tick every clk).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable_240hz  in  1  quarter-frame strobe, one clk wide; clocks the envelope
enable_120hz  in  1  half-frame strobe, one clk wide; clocks the length counter
channel_enable  in  1  $4015 bit 3; level input
reg_400C  in  8  [3:0] volume/period, [4] constant volume, [5] halt/loop
reg_400E  in  8  [3:0] period select, [7] mode
reg_400F  in  8  [7:3] length select
reg_change  in  1  toggle from another clock domain; each edge means $400F was written
length_active  out  1  length counter != 0 (feeds the $4015 read)
noise_out  out  VOL_WIDTH  registered sample to the mixer

Behaviour:
- Reset, asynchronous: all registers 0 except lfsr = 1. noise_out = 0, length_active = 0.
- Write detect:
  - reg_change passes through a 2-flop synchroniser.
  - Inequality of the two stages produces a registered one-clk reload pulse.
  - Length counter and envelope start flag update on the edge after the pulse.
- Prescaler:
  - Counts CLK_DIV-1 down to 0; tick = (count==0), then reload.
  - For CLK_DIV=1, tick is held at 1.
- Timer, acts on tick only:
  - count==0: load period_table[reg_400E[3:0]] and step the LFSR.
  - Otherwise decrement.
  - Period changes take effect at the next reload; a running count is never truncated.
- LFSR step:
  - fb = lfsr[0] ^ (mode ? lfsr[TAP_SHORT] : lfsr[1]).
  - lfsr = {fb, lfsr[LFSR_WIDTH-1:1]}.
  - If lfsr==0 on any non-step cycle, force 1.
- Length counter, 8 bits, priority highest first:
  - channel_enable==0 → clear to 0; reload is ignored.
  - reload → length_table[reg_400F[7:3]].
  - enable_120hz && !halt && count!=0 → decrement.
  - Reload coinciding with enable_120hz: reload wins, no decrement that cycle.
- Envelope: state is a start flag, a divider (VOL_WIDTH), and decay (VOL_WIDTH).
  - reload sets start.
  - On enable_240hz with start=1: clear start, decay = all ones, divider = reg_400C[3:0].
  - On enable_240hz with start=0 and divider==0: divider = reg_400C[3:0], then:
    - decay!=0 → decay decrements;
    - decay==0 and loop (bit 5) → decay = all ones;
    - otherwise decay holds at 0.
  - On enable_240hz with start=0 and divider!=0: divider decrements.
  - Reload and enable_240hz in the same cycle: start is set, and the strobe consumes it on the following strobe, not this one.
- Output, registered with 1-clk latency:
  - volume = constant ? reg_400C[3:0] : decay.
  - noise_out = 0 if length==0 or lfsr[0]==1, else volume.
- length_active is combinational from the length register.
- Reset mid-operation restores reset values immediately. The synchroniser also clears, so the first post-reset reg_change edge produces exactly one reload.

Decomposition:
- Package noise_pkg holds:
  - LENGTH_TABLE, 32×8: 0A FE 14 02 28 04 50 06 A0 08 3C 0A 0E 0C 1A 0E 0C 10 18 12 30 14 60 16 C0 18 48 1A 10 1C 20 1E.
  - PERIOD_TABLE, 16×12: 004 008 010 020 040 060 080 0A0 0CA 0FE 17C 1FC 2FA 3F8 7F2 FE4.
  - Default tap constants.
- Sub-module envelope_unit (start, divider, decay, loop, constant). It is shared later with the pulse channels.

Test Plan:
- Reset: assert rst mid-run → noise_out=0, length_active=0, lfsr=1 with no clk edge. Release, toggle reg_change once → exactly one reload.
- Length: reg_400F=0x08 (select 1) with enable=1, toggle → length=0xFE ≈3 clk later. 0xFE enable_120hz strobes → length_active falls, noise_out=0. With halt=1 the count freezes. Drop channel_enable → length is 0 the next edge.
- LFSR, mode=0: period select 0, CLK_DIV=1 → sequence repeats after 32767 steps, first states 1→0x4000→0x2000. With mode=1 → period 93. Force lfsr=0 → becomes 1.
- Envelope, constant=0, period=0, loop=0: toggle, then 16 quarter strobes → decay 15,14,…,0 and holds at 0. With loop=1, decay wraps 0→15.
- Constant volume: reg_400C=0x17, lfsr[0]=0, length!=0 → noise_out=7 one clk later. Set lfsr[0]=1 → 0.
- Prescaler: CLK_DIV=4, period select 0 → LFSR steps every 20 clk (5 ticks × 4).
